// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forwarding mux selects
// and the MUL/DIV sequencing states.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;   // operand from register file
   localparam logic [1:0] FWD_W  = 2'b01;   // operand from writeback stage
   localparam logic [1:0] FWD_M  = 2'b10;   // operand from memory stage

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/md_stall_ctrl.sv
// Sequencer for the multi-cycle MUL/DIV unit in Execute. Holds an op in E for
// MD_LATENCY cycles: busy (stall) for the first MD_LATENCY-1, done in the last.
module md_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic MdStartE,
   input  logic PCSrcE,
   output logic md_busy,
   output logic md_done
);

   localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
   // First busy cycle happens in IDLE, so the counter loads with two fewer.
   localparam logic [CW-1:0] CNT_LOAD = (MD_LATENCY > 1) ? CW'(MD_LATENCY - 2) : '0;

   md_state_t     state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;

   // State and remaining-cycle counter; reset aborts any op in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next state and busy/done decode; outputs forced low while reset is held.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      md_busy    = 1'b0;
      md_done    = 1'b0;
      case (state_reg)
         IDLE: begin
            // A taken branch kills the op in E, so it never starts.
            if (MdStartE && !PCSrcE && (MD_LATENCY > 1)) begin
               md_busy    = 1'b1;
               cnt_next   = CNT_LOAD;
               state_next = BUSY;
            end
            if (MD_LATENCY == 1) begin
               md_done = MdStartE;
            end
         end
         BUSY: begin
            // MdStartE is the same frozen instruction here, so it is ignored.
            if (cnt_reg != '0) begin
               md_busy  = 1'b1;
               cnt_next = cnt_reg - 1'b1;
            end else begin
               md_done    = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      if (!reset) begin
         md_busy = 1'b0;
         md_done = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_unit_mc.sv
// Five-stage pipeline hazard unit with E-stage forwarding, load-use stall,
// branch flush, multi-cycle MUL/DIV stall sequencing and a stall counter.
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              ResultSrcE0,
   input  logic              PCSrcE,
   input  logic              MdStartE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              MdDoneE,
   output logic [CNT_W-1:0]  StallCount
);

   logic             lw_stall;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cnt_reg;

   // One forwarding selector per E-stage source operand; M is newer than W.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [REG_AW-1:0] rs;
      logic [1:0]        sel;
      assign rs = (gi == 0) ? Rs1E : Rs2E;

      // Pick the youngest in-flight producer of this operand.
      always_comb begin
         sel = FWD_RF;
         if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
            sel = FWD_M;
         end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
            sel = FWD_W;
         end
      end
   end

   assign ForwardAE = g_fwd[0].sel;
   assign ForwardBE = g_fwd[1].sel;

   // A load in E whose destination is read in D must wait one cycle.
   assign lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

   md_stall_ctrl #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md (
      .clk      (clk),
      .reset    (reset),
      .MdStartE (MdStartE),
      .PCSrcE   (PCSrcE),
      .md_busy  (md_busy),
      .md_done  (MdDoneE)
   );

   // While MUL/DIV holds E, branch and load-use decisions are deferred.
   assign StallF = lw_stall || md_busy;
   assign StallD = lw_stall || md_busy;
   assign StallE = md_busy;
   assign FlushM = md_busy;
   assign FlushE = !md_busy && (lw_stall || PCSrcE);
   assign FlushD = !md_busy && PCSrcE;

   // Count front-end stall cycles, sticking at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg <= '0;
      end else if (StallF && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign StallCount = stall_cnt_reg;

endmodule
